// File: rtl/sy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sy_pkg
// Purpose  : Shared types and constants for the writeback arbitration path:
//            unit ids, writeback port count, register/data widths.
// Revision : 1.0  initial release
// ============================================================================
package sy_pkg;

  // Requester count and writeback port count
  localparam int NUM_REQ     = 5;
  localparam int NUM_WB_PORT = 2;

  // Physical register index width and datapath width
  localparam int PHY_REG_WTH = 7;
  localparam int XLEN        = 64;

  // Width of the source-unit id carried with each writeback
  localparam int WB_SRC_WTH  = 3;

  // Execution-unit ids; these also fix the requester slot order
  typedef enum logic [WB_SRC_WTH-1:0] {
    WB_ALU = 3'd0,
    WB_CSR = 3'd1,
    WB_LSU = 3'd2,
    WB_MDU = 3'd3,
    WB_FPU = 3'd4
  } wb_src_e;

  // One writeback port's worth of payload
  typedef struct packed {
    logic                   valid;
    logic [PHY_REG_WTH-1:0] idx;
    logic                   is_fp;
    logic [XLEN-1:0]        data;
    wb_src_e                src;
  } wb_port_t;

  // Only the LSU and the FPU can produce a floating-point destination
  function automatic logic unit_can_write_fp(input int unsigned unit);
    return (unit == int'(WB_LSU)) || (unit == int'(WB_FPU));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sy_ppl_rr_multi_grant.sv
`default_nettype none
// ============================================================================
// Module   : sy_ppl_rr_multi_grant
// Purpose  : Combinational N-of-M cyclic priority picker. Scans requesters
//            starting at the pointer, grants the first NUM_PORT that are
//            valid, assigns the k-th grant to port k, and returns the slot
//            after the last grant as the next pointer.
// Revision : 1.0  initial release
// ============================================================================
module sy_ppl_rr_multi_grant #(
  parameter int NUM_REQ  = 5,
  parameter int NUM_PORT = 2,
  parameter int PTR_WTH  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [PTR_WTH-1:0]          ptr_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic [NUM_PORT*NUM_REQ-1:0] sel_o,
  output logic [NUM_PORT-1:0]         port_vld_o,
  output logic [PTR_WTH-1:0]          nxt_ptr_o
);

  int w_cnt;
  int w_pos;

  // Walk the requesters in cyclic order from the pointer, handing out ports in order
  always_comb begin
    gnt_o      = '0;
    sel_o      = '0;
    port_vld_o = '0;
    nxt_ptr_o  = ptr_i;
    w_cnt      = 0;
    w_pos      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = (int'(ptr_i) + k) % NUM_REQ;
      for (int u = 0; u < NUM_REQ; u++) begin
        if ((u == w_pos) && req_i[u] && (w_cnt < NUM_PORT)) begin
          gnt_o[u] = 1'b1;
          for (int p = 0; p < NUM_PORT; p++) begin
            if (p == w_cnt) begin
              sel_o[p*NUM_REQ + u] = 1'b1;
              port_vld_o[p]        = 1'b1;
            end
          end
          nxt_ptr_o = PTR_WTH'((u + 1) % NUM_REQ);
          w_cnt     = w_cnt + 1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sy_ppl_wb_arb.sv
`default_nettype none
// ============================================================================
// Module   : sy_ppl_wb_arb
// Purpose  : Shares the physical-register writeback ports between the ALU,
//            CSR, LSU, MDU and FPU. Round-robin grants up to NUM_WB_PORT
//            results per cycle and registers them onto the writeback ports
//            feeding the register file and scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module sy_ppl_wb_arb #(
  parameter int NUM_REQ     = sy_pkg::NUM_REQ,
  parameter int NUM_WB_PORT = sy_pkg::NUM_WB_PORT,
  parameter int PHY_REG_WTH = sy_pkg::PHY_REG_WTH,
  parameter int XLEN        = sy_pkg::XLEN
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ*PHY_REG_WTH-1:0]    req_idx_i,
  input  logic [NUM_REQ-1:0]                req_is_fp_i,
  input  logic [NUM_REQ*XLEN-1:0]           req_data_i,
  output logic [NUM_WB_PORT-1:0]            wb_valid_o,
  output logic [NUM_WB_PORT*PHY_REG_WTH-1:0] wb_idx_o,
  output logic [NUM_WB_PORT-1:0]            wb_is_fp_o,
  output logic [NUM_WB_PORT*XLEN-1:0]       wb_data_o,
  output logic [NUM_WB_PORT*3-1:0]          wb_src_o
);

  import sy_pkg::*;

  localparam int PTR_WTH = $clog2(NUM_REQ);
  localparam int SRC_WTH = 3;

  logic [PTR_WTH-1:0]                 rr_q,       rr_d;
  logic [NUM_WB_PORT-1:0]             wb_valid_q, wb_valid_d;
  logic [NUM_WB_PORT*PHY_REG_WTH-1:0] wb_idx_q,   wb_idx_d;
  logic [NUM_WB_PORT-1:0]             wb_fp_q,    wb_fp_d;
  logic [NUM_WB_PORT*XLEN-1:0]        wb_data_q,  wb_data_d;
  logic [NUM_WB_PORT*SRC_WTH-1:0]     wb_src_q,   wb_src_d;

  logic [NUM_REQ-1:0]             w_gnt;
  logic [NUM_WB_PORT*NUM_REQ-1:0] w_sel;
  logic [NUM_WB_PORT-1:0]         w_port_vld;
  logic [PTR_WTH-1:0]             w_nxt_ptr;
  logic [NUM_REQ-1:0]             w_is_fp;
  logic                           w_collide;

  sy_ppl_rr_multi_grant #(
    .NUM_REQ  (NUM_REQ),
    .NUM_PORT (NUM_WB_PORT),
    .PTR_WTH  (PTR_WTH)
  ) u_pick (
    .req_i      (req_valid_i),
    .ptr_i      (rr_q),
    .gnt_o      (w_gnt),
    .sel_o      (w_sel),
    .port_vld_o (w_port_vld),
    .nxt_ptr_o  (w_nxt_ptr)
  );

  // Units without an FP destination cannot claim the FP file
  always_comb begin
    w_is_fp = '0;
    for (int u = 0; u < NUM_REQ; u++) begin
      w_is_fp[u] = req_is_fp_i[u] & unit_can_write_fp(u);
    end
  end

  // No handshake completes during reset or in a flush cycle
  assign req_ready_o = (rst_i && !flush_i) ? w_gnt : '0;

  // Steer each granted requester's payload onto its port; flush drops all grants
  always_comb begin
    wb_valid_d = '0;
    wb_idx_d   = '0;
    wb_fp_d    = '0;
    wb_data_d  = '0;
    wb_src_d   = '0;
    if (!flush_i) begin
      wb_valid_d = w_port_vld;
      for (int p = 0; p < NUM_WB_PORT; p++) begin
        for (int u = 0; u < NUM_REQ; u++) begin
          if (w_sel[p*NUM_REQ + u]) begin
            wb_idx_d[p*PHY_REG_WTH +: PHY_REG_WTH] = req_idx_i[u*PHY_REG_WTH +: PHY_REG_WTH];
            wb_fp_d[p]                             = w_is_fp[u];
            wb_data_d[p*XLEN +: XLEN]              = req_data_i[u*XLEN +: XLEN];
            wb_src_d[p*SRC_WTH +: SRC_WTH]         = SRC_WTH'(u);
          end
        end
      end
    end
  end

  // Pointer moves past the last grant; no grant leaves it in place; flush rewinds to ALU
  assign rr_d = flush_i ? '0 : w_nxt_ptr;

  // Writeback port and round-robin pointer registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_q       <= '0;
      wb_valid_q <= '0;
      wb_idx_q   <= '0;
      wb_fp_q    <= '0;
      wb_data_q  <= '0;
      wb_src_q   <= '0;
    end else begin
      rr_q       <= rr_d;
      wb_valid_q <= wb_valid_d;
      wb_idx_q   <= wb_idx_d;
      wb_fp_q    <= wb_fp_d;
      wb_data_q  <= wb_data_d;
      wb_src_q   <= wb_src_d;
    end
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_idx_o   = wb_idx_q;
  assign wb_is_fp_o = wb_fp_q;
  assign wb_data_o  = wb_data_q;
  assign wb_src_o   = wb_src_q;

  // Two ports writing the same register in one cycle means renaming broke
  always_comb begin
    w_collide = 1'b0;
    for (int a = 0; a < NUM_WB_PORT; a++) begin
      for (int b = a + 1; b < NUM_WB_PORT; b++) begin
        if (wb_valid_d[a] && wb_valid_d[b] &&
            (wb_idx_d[a*PHY_REG_WTH +: PHY_REG_WTH] == wb_idx_d[b*PHY_REG_WTH +: PHY_REG_WTH]) &&
            (wb_fp_d[a] == wb_fp_d[b])) begin
          w_collide = 1'b1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_no_dest_collision: assert property (@(posedge clk_i) disable iff (!rst_i) !w_collide);
`endif

endmodule
`default_nettype wire

// File: tb/tb_sy_ppl_wb_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sy_ppl_wb_arb
// Purpose  : Self-checking bench for the writeback arbiter: directed
//            scenarios plus randomized traffic against a list-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sy_ppl_wb_arb;
  import sy_pkg::*;

  localparam int NR = 5;
  localparam int NP = 2;
  localparam int IW = PHY_REG_WTH;
  localparam int XW = XLEN;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                flush_i;
  logic [NR-1:0]       req_valid_i;
  logic [NR-1:0]       req_ready_o;
  logic [NR*IW-1:0]    req_idx_i;
  logic [NR-1:0]       req_is_fp_i;
  logic [NR*XW-1:0]    req_data_i;
  logic [NP-1:0]       wb_valid_o;
  logic [NP*IW-1:0]    wb_idx_o;
  logic [NP-1:0]       wb_is_fp_o;
  logic [NP*XW-1:0]    wb_data_o;
  logic [NP*3-1:0]     wb_src_o;

  int checks = 0;
  int errors = 0;

  logic [IW-1:0] p_idx  [NR];
  logic          p_fp   [NR];
  logic [XW-1:0] p_data [NR];

  sy_ppl_wb_arb u_dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_idx_i   (req_idx_i),
    .req_is_fp_i (req_is_fp_i),
    .req_data_i  (req_data_i),
    .wb_valid_o  (wb_valid_o),
    .wb_idx_o    (wb_idx_o),
    .wb_is_fp_o  (wb_is_fp_o),
    .wb_data_o   (wb_data_o),
    .wb_src_o    (wb_src_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [NR-1:0] vld, input logic fl);
    req_valid_i = vld;
    flush_i     = fl;
    for (int i = 0; i < NR; i++) begin
      req_idx_i[i*IW +: IW]  = p_idx[i];
      req_is_fp_i[i]         = p_fp[i];
      req_data_i[i*XW +: XW] = p_data[i];
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference arbitration: walk units cyclically from rr, first NP valid ones win
  function automatic void model_pick(input logic [NR-1:0] vld, input logic fl, input int rr,
                                     output logic [NR-1:0] gnt, output int w0, output int w1,
                                     output int rr_n);
    int n;
    gnt = '0; w0 = -1; w1 = -1; n = 0;
    rr_n = fl ? 0 : rr;
    if (!fl) begin
      for (int k = 0; k < NR; k++) begin
        int u;
        u = (rr + k) % NR;
        if (vld[u] && n < NP) begin
          gnt[u] = 1'b1;
          if (n == 0) w0 = u; else w1 = u;
          n++;
          rr_n = (u + 1) % NR;
        end
      end
    end
  endfunction

  task automatic test_reset();
    for (int i = 0; i < NR; i++) begin
      p_idx[i] = IW'(i + 1); p_fp[i] = 1'b0; p_data[i] = XW'(64'h100 + i);
    end
    rst_i = 1'b0;
    drive('1, 1'b0);
    #12;
    checks++;
    if (req_ready_o !== 5'b00000) begin errors++; $display("FAIL reset_ready: got %b want 00000", req_ready_o); end
    checks++;
    if (wb_valid_o !== 2'b00) begin errors++; $display("FAIL reset_wb_valid: got %b want 00", wb_valid_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 5'b00011) begin errors++; $display("FAIL post_reset_ready: got %b want 00011", req_ready_o); end
    tick();
    checks++;
    if (wb_valid_o !== 2'b11 || wb_src_o !== 6'b001_000 || wb_data_o[XW-1:0] !== 64'h100) begin
      errors++; $display("FAIL post_reset_grant: valid %b src %b data0 %h want 11 001000 100", wb_valid_o, wb_src_o, wb_data_o[XW-1:0]);
    end
    drive('0, 1'b0);
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if (wb_valid_o !== 2'b00 || wb_idx_o !== '0 || wb_is_fp_o !== 2'b00 || wb_data_o !== '0 || wb_src_o !== '0) begin
      errors++; $display("FAIL async_reset_clear: valid %b idx %h fp %b src %b", wb_valid_o, wb_idx_o, wb_is_fp_o, wb_src_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_single();
    p_idx[0] = 7; p_data[0] = 64'h55; p_fp[0] = 1'b0;
    drive(5'b00001, 1'b0);
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 5'b00001) begin errors++; $display("FAIL single_ready: got %b want 00001", req_ready_o); end
    tick();
    checks++;
    if (wb_valid_o !== 2'b01 || wb_idx_o[IW-1:0] !== 7'd7 || wb_data_o[XW-1:0] !== 64'h55 ||
        wb_src_o[2:0] !== 3'd0 || wb_is_fp_o[0] !== 1'b0) begin
      errors++; $display("FAIL single_wb: valid %b idx %0d data %h src %0d fp %b want 01 7 55 0 0",
                         wb_valid_o, wb_idx_o[IW-1:0], wb_data_o[XW-1:0], wb_src_o[2:0], wb_is_fp_o[0]);
    end
    drive('0, 1'b0);
    tick();
    checks++;
    if (wb_valid_o !== 2'b00) begin errors++; $display("FAIL idle_clear: got %b want 00", wb_valid_o); end
  endtask

  task automatic test_flush();
    // pointer sits at CSR here; three units pending when the flush hits
    drive(5'b10101, 1'b1);
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 5'b00000) begin errors++; $display("FAIL flush_ready: got %b want 00000", req_ready_o); end
    tick();
    checks++;
    if (wb_valid_o !== 2'b00) begin errors++; $display("FAIL flush_wb_valid: got %b want 00", wb_valid_o); end
    drive(5'b10101, 1'b0);
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 5'b00101) begin errors++; $display("FAIL flush_restart_ready: got %b want 00101", req_ready_o); end
    tick();
    checks++;
    if (wb_valid_o !== 2'b11 || wb_src_o !== 6'b010_000) begin
      errors++; $display("FAIL flush_restart_wb: valid %b src %b want 11 010000", wb_valid_o, wb_src_o);
    end
    drive(5'b10000, 1'b0);
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 5'b10000) begin errors++; $display("FAIL flush_tail_ready: got %b want 10000", req_ready_o); end
    tick();
    drive('0, 1'b0);
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_rdy [4];
    logic [5:0]    exp_src [4];
    logic [NR-1:0] seen    [4];
    exp_rdy[0] = 5'b00011; exp_src[0] = 6'b001_000;
    exp_rdy[1] = 5'b01100; exp_src[1] = 6'b011_010;
    exp_rdy[2] = 5'b10001; exp_src[2] = 6'b000_100;
    exp_rdy[3] = 5'b00110; exp_src[3] = 6'b010_001;
    for (int i = 0; i < NR; i++) begin
      p_idx[i] = IW'(20 + i); p_fp[i] = 1'b0; p_data[i] = XW'(64'hA0 + i);
    end
    drive('1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      seen[c] = req_ready_o;
      checks++;
      if (req_ready_o !== exp_rdy[c]) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready_o, exp_rdy[c]); end
      tick();
      checks++;
      if (wb_valid_o !== 2'b11 || wb_src_o !== exp_src[c]) begin
        errors++; $display("FAIL rr_src[%0d]: valid %b src %b want 11 %b", c, wb_valid_o, wb_src_o, exp_src[c]);
      end
    end
    for (int w = 0; w < 2; w++) begin
      checks++;
      if ((seen[w] | seen[w+1] | seen[w+2]) !== 5'b11111) begin
        errors++; $display("FAIL rr_window[%0d]: got %b want 11111", w, seen[w] | seen[w+1] | seen[w+2]);
      end
    end
    drive('0, 1'b0);
  endtask

  task automatic test_fp_routing();
    drive('0, 1'b1);
    tick();
    p_idx[2] = 12; p_fp[2] = 1'b1; p_data[2] = 64'hDEAD;
    p_idx[4] = 12; p_fp[4] = 1'b0; p_data[4] = 64'hBEEF;
    drive(5'b10100, 1'b0);
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 5'b10100) begin errors++; $display("FAIL fp_route_ready: got %b want 10100", req_ready_o); end
    tick();
    checks++;
    if (wb_valid_o !== 2'b11 || wb_idx_o[IW-1:0] !== 7'd12 || wb_is_fp_o[0] !== 1'b1 || wb_src_o[2:0] !== 3'd2 ||
        wb_idx_o[IW +: IW] !== 7'd12 || wb_is_fp_o[1] !== 1'b0 || wb_src_o[5:3] !== 3'd4 ||
        wb_data_o[XW-1:0] !== 64'hDEAD || wb_data_o[XW +: XW] !== 64'hBEEF) begin
      errors++; $display("FAIL fp_route_wb: valid %b idx %h fp %b src %b want 11 (12,1,2) (12,0,4)",
                         wb_valid_o, wb_idx_o, wb_is_fp_o, wb_src_o);
    end
    drive('0, 1'b0);
  endtask

  task automatic test_fp_mask();
    p_idx[3] = 33; p_fp[3] = 1'b1; p_data[3] = 64'h3333;
    drive(5'b01000, 1'b0);
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 5'b01000) begin errors++; $display("FAIL fp_mask_ready: got %b want 01000", req_ready_o); end
    tick();
    checks++;
    if (wb_valid_o !== 2'b01 || wb_src_o[2:0] !== 3'd3 || wb_is_fp_o[0] !== 1'b0 || wb_idx_o[IW-1:0] !== 7'd33) begin
      errors++; $display("FAIL fp_mask_wb: valid %b src %0d fp %b idx %0d want 01 3 0 33",
                         wb_valid_o, wb_src_o[2:0], wb_is_fp_o[0], wb_idx_o[IW-1:0]);
    end
    drive('0, 1'b0);
  endtask

  task automatic test_random(input int rr_start, input int cycles);
    logic [NR-1:0] pend;
    logic [NR-1:0] gnt;
    logic          fl;
    int            rr_m, rr_n, w0, w1, ew;
    int            waits [NR];
    rr_m = rr_start;
    pend = '0;
    for (int i = 0; i < NR; i++) waits[i] = 0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && ($urandom_range(9) < 6)) begin
          pend[i]   = 1'b1;
          p_idx[i]  = IW'(i * 20 + $urandom_range(19));
          p_fp[i]   = 1'($urandom_range(1));
          p_data[i] = {$urandom, $urandom};
          waits[i]  = 0;
        end
      end
      fl = ($urandom_range(19) == 0);
      drive(pend, fl);
      model_pick(pend, fl, rr_m, gnt, w0, w1, rr_n);
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== gnt) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready_o, gnt); end
      for (int i = 0; i < NR; i++) begin
        if (fl) waits[i] = 0;
        else if (pend[i] && req_ready_o[i]) begin
          checks++;
          if (waits[i] > 2) begin errors++; $display("FAIL rand_starve[%0d]: unit %0d waited %0d want <=2", c, i, waits[i]); end
          waits[i] = 0;
        end else if (pend[i]) waits[i]++;
      end
      tick();
      for (int p = 0; p < NP; p++) begin
        ew = (p == 0) ? w0 : w1;
        checks++;
        if (ew < 0) begin
          if (wb_valid_o[p] !== 1'b0) begin errors++; $display("FAIL rand_port%0d_valid[%0d]: got 1 want 0", p, c); end
        end else if (wb_valid_o[p] !== 1'b1 || wb_src_o[p*3 +: 3] !== 3'(ew) ||
                     wb_idx_o[p*IW +: IW] !== p_idx[ew] || wb_data_o[p*XW +: XW] !== p_data[ew] ||
                     wb_is_fp_o[p] !== (p_fp[ew] && (ew == 2 || ew == 4))) begin
          errors++; $display("FAIL rand_port%0d[%0d]: valid %b src %0d idx %0d fp %b data %h want src %0d idx %0d data %h",
                             p, c, wb_valid_o[p], wb_src_o[p*3 +: 3], wb_idx_o[p*IW +: IW], wb_is_fp_o[p],
                             wb_data_o[p*XW +: XW], ew, p_idx[ew], p_data[ew]);
        end
      end
      pend = pend & ~gnt;
      rr_m = rr_n;
    end
    drive('0, 1'b0);
  endtask

  initial begin
    flush_i     = 1'b0;
    req_valid_i = '0;
    req_idx_i   = '0;
    req_is_fp_i = '0;
    req_data_i  = '0;
    test_reset();
    test_single();
    test_flush();
    test_round_robin();
    test_fp_routing();
    test_fp_mask();
    test_random(4, 400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
